// File: rtl/alu_seq.sv
// alu_seq: sequencer for the nibble-serial 8-bit ALU.
//   Takes one op per valid/ready request, drives the ALU over three cycles
//   (load A, low nibble, high nibble), then offers result + Z/N/H/C flags on
//   a valid/ready response. Illegal op codes skip the ALU and answer at once.
//   Ports: clk, reset (async, active-high); req_* request channel;
//   rsp_* response channel; alu_* ALU control outputs; alu_result/alu_carry
//   from the ALU.
//   Build option: define ALU_SEQ_INCDEC_EN to make op codes 8 (INC) and
//   9 (DEC) legal; otherwise they take the illegal-op path.
module alu_seq #(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [7:0]      req_a,
    input  logic [7:0]      req_b,
    input  logic            req_cy,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [7:0]      rsp_result,
    output logic            rsp_wr,
    output logic            rsp_z,
    output logic            rsp_n,
    output logic            rsp_h,
    output logic            rsp_c,
    output logic            rsp_err,
    output logic [7:0]      alu_op,
    output logic            alu_la,
    output logic            alu_lb,
    output logic            alu_ne,
    output logic            alu_ci,
    output logic            alu_l,
    output logic            alu_h,
    output logic            alu_r,
    output logic            alu_s,
    output logic            alu_v,
    output logic            alu_res_oe,
    input  logic [7:0]      alu_result,
    input  logic            alu_carry
);
    localparam logic [OP_W-1:0] OP_ADC = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SBC = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_CP  = OP_W'(7);

    typedef enum logic [2:0] {IDLE, LDA, LO, HI, RSP} state_t;

    state_t          state, state_nx;
    logic [OP_W-1:0] op;
    logic [7:0]      a, b;
    logic            cy, hc;
    logic            req_legal, incdec, dec, ne, ci_lo, lr, ls, lv, logic_op, busy;

`ifdef ALU_SEQ_INCDEC_EN
    localparam logic [OP_W-1:0] OP_INC = OP_W'(8);
    localparam logic [OP_W-1:0] OP_DEC = OP_W'(9);
    assign req_legal = req_op <= OP_DEC;
    assign incdec    = op == OP_INC || op == OP_DEC;
    assign dec       = op == OP_DEC;
`else
    assign req_legal = req_op <= OP_CP;
    assign incdec    = 1'b0;
    assign dec       = 1'b0;
`endif

    assign lr       = op == OP_AND;
    assign ls       = op == OP_XOR;
    assign lv       = op == OP_OR;
    assign logic_op = lr || ls || lv;
    assign ne       = op == OP_SUB || op == OP_SBC || op == OP_CP || dec;
    // Carry-in for the low nibble; subtraction is A + ~B + 1 so borrow-in inverts.
    assign ci_lo    = op == OP_ADC ? cy :
                      (op == OP_SUB || op == OP_CP) ? 1'b1 :
                      op == OP_SBC ? !cy : dec;
    assign busy     = state == LO || state == HI;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RSP;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = req_legal ? LDA : RSP;
            LDA:     state_nx = LO;
            LO:      state_nx = HI;
            HI:      state_nx = RSP;
            RSP:     if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        alu_la     = state == LDA;
        alu_lb     = state == LO;
        alu_l      = state == LO;
        alu_h      = state == HI;
        alu_res_oe = state == HI;
        alu_op     = state == LDA ? a : state == LO ? (incdec ? 8'h01 : b) : 8'h00;
        alu_ne     = busy && ne;
        alu_ci     = state == LO ? ci_lo : state == HI ? hc : 1'b0;
        alu_r      = busy && lr;
        alu_s      = busy && ls;
        alu_v      = busy && lv;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op         <= '0;
            a          <= '0;
            b          <= '0;
            cy         <= 1'b0;
            hc         <= 1'b0;
            rsp_result <= '0;
            rsp_wr     <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_h      <= 1'b0;
            rsp_c      <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                op <= req_op;
                a  <= req_a;
                b  <= req_b;
                cy <= req_cy;
                if (!req_legal) begin
                    rsp_result <= req_a;
                    rsp_c      <= req_cy;
                    rsp_err    <= 1'b1;
                    rsp_wr     <= 1'b0;
                    rsp_z      <= 1'b0;
                    rsp_n      <= 1'b0;
                    rsp_h      <= 1'b0;
                end
            end
            if (state == LO) hc <= alu_carry;
            if (state == HI) begin
                rsp_result <= alu_result;
                rsp_z      <= alu_result == 8'h00;
                rsp_n      <= ne;
                // With ne=1 the ALU carry is an active-low borrow, so flip it.
                rsp_h      <= logic_op ? lr : hc ^ ne;
                rsp_c      <= incdec ? cy : logic_op ? 1'b0 : alu_carry ^ ne;
                rsp_wr     <= op != OP_CP;
                rsp_err    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with a nibble-serial ALU stand-in.
module tb_alu_seq;
    logic       clk = 1'b0, reset = 1'b1;
    logic       req_valid = 1'b0, req_ready;
    logic [3:0] req_op = '0;
    logic [7:0] req_a = '0, req_b = '0;
    logic       req_cy = 1'b0;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic       rsp_wr, rsp_z, rsp_n, rsp_h, rsp_c, rsp_err;
    logic [7:0] alu_op, alu_result;
    logic       alu_la, alu_lb, alu_ne, alu_ci, alu_l, alu_h, alu_r, alu_s, alu_v, alu_res_oe;
    logic       alu_carry;

    int         total = 0, bad = 0, act_cnt = 0;
    logic [4:0] lo_ctl = '0, hi_ctl = '0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b;
        logic       cy;
        logic [7:0] res;
        logic [5:0] fl;
    } vec_t;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cy(req_cy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_wr(rsp_wr), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_h(rsp_h), .rsp_c(rsp_c),
        .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_la(alu_la), .alu_lb(alu_lb), .alu_ne(alu_ne), .alu_ci(alu_ci),
        .alu_l(alu_l), .alu_h(alu_h), .alu_r(alu_r), .alu_s(alu_s), .alu_v(alu_v),
        .alu_res_oe(alu_res_oe), .alu_result(alu_result), .alu_carry(alu_carry)
    );

    wire [17:0] alu_bus = {alu_op, alu_la, alu_lb, alu_ne, alu_ci, alu_l, alu_h,
                           alu_r, alu_s, alu_v, alu_res_oe};
    wire [13:0] rsp_bus = {rsp_result, rsp_z, rsp_n, rsp_h, rsp_c, rsp_wr, rsp_err};

    // ALU stand-in: one nibble per cycle, B taken from the bus during the low nibble.
    logic [7:0] ra = '0, rb = '0;
    logic [3:0] lo_res = '0;
    logic [4:0] lo_t, hi_t;

    function automatic logic [4:0] nib(input logic [3:0] x, y, input logic ci, ne, r, s, v);
        logic [3:0] yy;
        yy = ne ? ~y : y;
        return r ? {1'b0, x & y} : s ? {1'b0, x ^ y} : v ? {1'b0, x | y} :
               {1'b0, x} + {1'b0, yy} + {4'b0, ci};
    endfunction

    assign lo_t       = nib(ra[3:0], alu_op[3:0], alu_ci, alu_ne, alu_r, alu_s, alu_v);
    assign hi_t       = nib(ra[7:4], rb[7:4], alu_ci, alu_ne, alu_r, alu_s, alu_v);
    assign alu_result = alu_h ? (alu_res_oe ? {hi_t[3:0], lo_res} : 8'h5A) :
                        alu_l ? {4'h0, lo_t[3:0]} : 8'h00;
    assign alu_carry  = alu_h ? hi_t[4] : alu_l ? lo_t[4] : 1'b0;

    always @(posedge clk) begin
        if (alu_la) ra <= alu_op;
        if (alu_lb) rb <= alu_op;
        if (alu_l) lo_res <= lo_t[3:0];
    end

    always @(negedge clk) begin
        if (alu_bus != '0) act_cnt++;
        if (alu_l) lo_ctl = {alu_ne, alu_ci, alu_r, alu_s, alu_v};
        if (alu_h) hi_ctl = {alu_ne, alu_ci, alu_r, alu_s, alu_v};
    end

    // Reference: flags from whole-byte arithmetic, fl = {z,n,h,c,wr,err}.
    function automatic vec_t model(input logic [3:0] op, input logic [7:0] a, b, input logic cy);
        vec_t v;
        int   o, ia, ib, cin, r;
        logic z, n, h, c, wr, err;
        o = int'(op); ia = int'(a); ib = int'(b);
        cin = (o == 1 || o == 3) ? int'(cy) : 0;
        n = 0; h = 0; c = 0; wr = 1; err = 0; r = 0;
        case (o)
            0, 1: begin r = ia + ib + cin; h = (ia % 16 + ib % 16 + cin) > 15; c = r > 255; end
            2, 3, 7: begin
                r = ia - ib - cin; h = (ia % 16 - ib % 16 - cin) < 0; c = r < 0;
                n = 1; wr = o != 7;
            end
            4: begin r = ia & ib; h = 1; end
            5: r = ia ^ ib;
            6: r = ia | ib;
`ifdef ALU_SEQ_INCDEC_EN
            8: begin r = ia + 1; h = ia % 16 == 15; c = cy; end
            9: begin r = ia - 1; h = ia % 16 == 0; c = cy; n = 1; end
`endif
            default: begin r = ia; c = cy; wr = 0; err = 1; end
        endcase
        v.op = op; v.a = a; v.b = b; v.cy = cy;
        v.res = 8'(r);
        z = !err && v.res == 8'h00;
        v.fl = {z, n, h, c, wr, err};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the sequencer idle.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, b, input logic cy, output int lat);
        chk("req_ready before issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cy = cy;
        act_cnt = 0; lo_ctl = '0; hi_ctl = '0;
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1 lat++;
        end
    endtask

    task automatic check_rsp(input string name, input vec_t e, input int lat);
        chk({name, " latency"}, 32'(lat), e.fl[0] ? 32'd1 : 32'd4);
        chk({name, " result"}, 32'(rsp_result), 32'(e.res));
        chk({name, " flags zn-h-c-wr-err"}, 32'({rsp_z, rsp_n, rsp_h, rsp_c, rsp_wr, rsp_err}), 32'(e.fl));
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        chk("rsp_valid after handshake", 32'(rsp_valid), 32'd0);
        chk("req_ready after handshake", 32'(req_ready), 32'd1);
    endtask

    initial begin
        vec_t tbl[9];
        vec_t e;
        int   lat;
        tbl[0] = '{4'd0,  8'h3A, 8'hC6, 1'b0, 8'h00, 6'b101110};
        tbl[1] = '{4'd3,  8'h3B, 8'h4F, 1'b1, 8'hEB, 6'b011110};
        tbl[2] = '{4'd7,  8'h90, 8'h91, 1'b0, 8'hFF, 6'b011100};
        tbl[3] = '{4'd4,  8'h5A, 8'h3F, 1'b0, 8'h1A, 6'b001010};
        tbl[4] = '{4'd12, 8'h77, 8'h12, 1'b1, 8'h77, 6'b000101};
        tbl[5] = '{4'd5,  8'h0F, 8'hF0, 1'b1, 8'hFF, 6'b000010};
        tbl[6] = '{4'd6,  8'h00, 8'h00, 1'b0, 8'h00, 6'b100010};
        tbl[7] = '{4'd1,  8'h0F, 8'h00, 1'b1, 8'h10, 6'b001010};
`ifdef ALU_SEQ_INCDEC_EN
        tbl[8] = '{4'd8,  8'hFF, 8'h55, 1'b0, 8'h00, 6'b101010};
`else
        tbl[8] = '{4'd8,  8'hFF, 8'h55, 1'b0, 8'hFF, 6'b000001};
`endif

        #12;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp outputs", 32'(rsp_bus), 32'd0);
        chk("reset alu outputs", 32'(alu_bus), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cy, lat);
            check_rsp($sformatf("vec%0d", i), tbl[i], lat);
            if (tbl[i].op == 4'd3) chk("SBC low ne/ci", 32'(lo_ctl[4:3]), 32'b10);
            if (tbl[i].op == 4'd4) chk("AND alu_r lo/hi", 32'({lo_ctl[2], hi_ctl[2]}), 32'b11);
            if (tbl[i].fl[0]) chk("illegal alu activity", 32'(act_cnt), 32'd0);
            complete();
        end

        for (int k = 0; k < 150; k++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            logic       cy;
            op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom); cy = 1'($urandom);
            e = model(op, a, b, cy);
            issue(op, a, b, cy, lat);
            check_rsp($sformatf("rnd op=%0d a=%h b=%h cy=%0d", op, a, b, cy), e, lat);
            complete();
        end

        e = model(4'd2, 8'h3E, 8'h3E, 1'b0);
        issue(4'd2, 8'h3E, 8'h3E, 1'b0, lat);
        check_rsp("bp SUB", e, lat);
        req_valid = 1'b1; req_op = 4'd0; req_a = 8'h11; req_b = 8'h22;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp rsp_valid held", 32'(rsp_valid), 32'd1);
            chk("bp rsp held", 32'(rsp_bus), 32'({8'h00, 6'b110010}));
            chk("bp req_ready low", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        complete();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 chk("bp no stray rsp", 32'(rsp_valid), 32'd0);
        end

        req_valid = 1'b1; req_op = 4'd0; req_a = 8'h12; req_b = 8'h34; req_cy = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 chk("in LO before reset", 32'(alu_l), 32'd1);
        reset = 1'b1; #1;
        chk("mid reset alu outputs", 32'(alu_bus), 32'd0);
        chk("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid reset rsp outputs", 32'(rsp_bus), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        chk("after reset req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 chk("after reset no stray rsp", 32'(rsp_valid), 32'd0);
        end
        e = model(4'd0, 8'h99, 8'h88, 1'b0);
        issue(4'd0, 8'h99, 8'h88, 1'b0, lat);
        check_rsp("after reset ADD", e, lat);
        complete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
